fp_result_logger: RTL

//  Capture side of the FP execution test path: records each operation issued to fp_unit

---
 rtl/fp_result_logger_if.sv | 10 +
 rtl/fp_result_logger.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp_result_logger_if.sv
// Record-word stream from fp_result_logger to the host/UART dumper.
interface fp_result_logger_if;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        tx_ready;

    modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/fp_result_logger.sv
// Logs each fp_unit operation with its result/flags, buffers records and streams 32-bit words.
// Define FP_LOG_HDR_EN to prefix every record with a {A5, seq, 0000} header word.
module fp_result_logger #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_enable,
    input  logic [31:0]            in_data1,
    input  logic [31:0]            in_data2,
    input  logic [2:0]             in_rm,
    input  logic [31:0]            out_result,
    input  logic [4:0]             out_flags,
    input  logic                   clear,
    fp_result_logger_if.master     tx,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            drop_cnt,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef struct packed {
`ifdef FP_LOG_HDR_EN
        logic [7:0]  seq;
`endif
        logic [31:0] data1;
        logic [31:0] data2;
        logic [2:0]  rm;
        logic [31:0] result;
        logic [4:0]  flags;
    } rec_t;

    typedef enum logic [2:0] {IDLE, WH, W0, W1, W2, W3} state_t;
`ifdef FP_LOG_HDR_EN
    localparam state_t FIRST = WH;
`else
    localparam state_t FIRST = W0;
`endif

    logic        en_p    [LATENCY];
    logic [31:0] data1_p [LATENCY];
    logic [31:0] data2_p [LATENCY];
    logic [2:0]  rm_p    [LATENCY];

    rec_t        mem [DEPTH];
    rec_t        new_rec;
    rec_t        hold;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop, drop;
    state_t      state, state_next;
`ifdef FP_LOG_HDR_EN
    logic [7:0]  seq;
`endif

    // Align pipe: operands travel LATENCY stages to meet fp_unit's result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                en_p[i]    <= 1'b0;
                data1_p[i] <= '0;
                data2_p[i] <= '0;
                rm_p[i]    <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < LATENCY; i++) begin
                en_p[i]    <= 1'b0;
                data1_p[i] <= '0;
                data2_p[i] <= '0;
                rm_p[i]    <= '0;
            end
        end else begin
            en_p[0]    <= in_enable;
            data1_p[0] <= in_data1;
            data2_p[0] <= in_data2;
            rm_p[0]    <= in_rm;
            for (int i = 1; i < LATENCY; i++) begin
                en_p[i]    <= en_p[i-1];
                data1_p[i] <= data1_p[i-1];
                data2_p[i] <= data2_p[i-1];
                rm_p[i]    <= rm_p[i-1];
            end
        end
    end

    always_comb begin
        new_rec        = '0;
        new_rec.data1  = data1_p[LATENCY-1];
        new_rec.data2  = data2_p[LATENCY-1];
        new_rec.rm     = rm_p[LATENCY-1];
        new_rec.result = out_result;
        new_rec.flags  = out_flags;
`ifdef FP_LOG_HDR_EN
        new_rec.seq    = seq;
`endif
    end

    // FIFO: a pop in the same cycle frees the slot a full-FIFO push needs
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign push  = en_p[LATENCY-1] && (!full || pop);
    assign drop  = en_p[LATENCY-1] && full && !pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
`ifdef FP_LOG_HDR_EN
            seq      <= '0;
`endif
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
`ifdef FP_LOG_HDR_EN
            seq      <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                overflow <= 1'b1;
            end
`ifdef FP_LOG_HDR_EN
            if (push) seq <= seq + 8'd1;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= new_rec;
    end

    // Serializer: hold register only changes on pop, so tx_data is stable while stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hold  <= '0;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
            if (pop) hold <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                state_next = FIRST;
            end
            WH: if (tx.tx_ready) state_next = W0;
            W0: if (tx.tx_ready) state_next = W1;
            W1: if (tx.tx_ready) state_next = W2;
            W2: if (tx.tx_ready) state_next = W3;
            W3: if (tx.tx_ready) begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = FIRST;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx.tx_valid = (state != IDLE);
        tx.tx_last  = (state == W3);
        tx.tx_data  = '0;
        case (state)
`ifdef FP_LOG_HDR_EN
            WH: tx.tx_data = {8'hA5, hold.seq, 16'h0000};
`endif
            W0: tx.tx_data = hold.data1;
            W1: tx.tx_data = hold.data2;
            W2: tx.tx_data = hold.result;
            W3: tx.tx_data = {24'h0, hold.rm, hold.flags};
            default: tx.tx_data = '0;
        endcase
    end
endmodule
